uart_word_rx: RTL and testbench
===============================

UART_WORD_RX -- requirements
Module: uart_word_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clock cycles per serial bit (50 MHz / 115200 baud).
REQ-002 SHALL have parameter BYTES_PER_WORD, default 2, meaning bytes assembled per output word (legal range 1..4).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port from_computer, input, 1 bit: asynchronous serial line; idles high.
REQ-006 SHALL have port word_out, output, 8*BYTES_PER_WORD bits: the assembled word; the first byte received is the most significant byte.
REQ-007 SHALL have port word_valid, output, 1 bit: word_out holds an unconsumed word.
REQ-008 SHALL have port word_ready, input, 1 bit: consumer accepts the word when word_valid and word_ready are both high on a clock edge.
REQ-009 SHALL have port frame_err, output, 1 bit: one-cycle pulse when a stop bit is sampled low.
REQ-010 SHALL have port overrun, output, 1 bit: one-cycle pulse when a completed word is dropped.

Function
REQ-011 SHALL pass from_computer through a 2-flop synchronizer; all later references to "line" mean the synchronized value.
REQ-012 SHALL implement an FSM with states IDLE, START, DATA, PARITY (present only per REQ-024) and STOP.
REQ-013 IDLE: a line low sample SHALL enter START and clear the bit counter.
REQ-014 START: at count CLKS_PER_BIT/2 (integer division), line high SHALL return to IDLE (glitch rejected, no error); line low SHALL restart the counter and enter DATA.
REQ-015 DATA: SHALL sample 8 bits, each at CLKS_PER_BIT counts after the previous sample, LSB first within the byte, then enter PARITY or STOP.
REQ-016 STOP: SHALL sample the line CLKS_PER_BIT counts after the last data/parity sample. High: store the byte and return to IDLE. Low: pulse frame_err, discard the byte, reset the byte index to 0, and stay in STOP until the line is high, then go to IDLE.
REQ-017 The byte index SHALL run 0..BYTES_PER_WORD-1. Storing the byte at the last index SHALL complete the word and wrap the index to 0.
REQ-018 On word completion, word_out and word_valid SHALL update on the clock edge after the stop-bit sample (1-cycle latency).
REQ-019 Word completion with word_valid=0, or with word_valid=1 and word_ready=1 in the same cycle, SHALL load the new word and leave word_valid=1.
REQ-020 Word completion with word_valid=1 and word_ready=0 SHALL keep the old word, drop the new one, and pulse overrun.
REQ-021 word_valid&&word_ready with no completion in the same cycle SHALL clear word_valid on the next edge; word_out SHALL hold its value.

Reset
REQ-022 rst SHALL immediately force: FSM to IDLE, all counters and the byte index to 0, word_out=0, word_valid=0, frame_err=0, overrun=0, synchronizer flops=1.
REQ-023 A reset asserted mid-frame SHALL abandon any partial word; after release the block SHALL wait for the next line-low sample in IDLE.

Configuration
REQ-024 With macro UART_WORD_RX_PARITY_EN defined, the block SHALL include the PARITY state and sample one even-parity bit after the data bits. On mismatch it SHALL pulse frame_err, discard the byte and reset the byte index to 0, then continue to STOP. Without the macro, the PARITY state, its logic and its timing slot SHALL be absent.

Verification
REQ-025 Defaults, no parity: send 0x01 then 0x25 at 8680 ns/bit, word_ready=1 -> word_out=0x0125, word_valid high for exactly 1 cycle.
REQ-026 Send 0x01,0x25 with word_ready=0, then 0xAB,0xCD -> word_out stays 0x0125, overrun pulses once; after word_ready=1 for one cycle, word_valid=0.
REQ-027 Send 0x01 with stop bit low, then 0x12,0x34 -> frame_err pulses once; word_out=0x1234 (the index was reset).
REQ-028 Drive a 2000 ns low glitch on an idle line -> no state leaves IDLE beyond START, and no word_valid or frame_err pulse.
REQ-029 Assert rst in the middle of the second byte, then send 0x56,0x78 -> word_out=0x5678, word_valid=1, no overrun.
REQ-030 With UART_WORD_RX_PARITY_EN defined: send 0x25 with parity bit 0 (wrong; correct is 1) -> frame_err pulses and the byte is discarded; 0x01,0x25 sent with correct parity -> word_out=0x0125.

Source files
------------

// File: rtl/uart_word_rx.sv
// UART receiver (8N1) that packs BYTES_PER_WORD bytes, first byte most significant, into one word.
// Define UART_WORD_RX_PARITY_EN to add an even-parity bit after the data bits.
module uart_word_rx #(
  parameter int CLKS_PER_BIT   = 434,
  parameter int BYTES_PER_WORD = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        from_computer,
  output logic [8*BYTES_PER_WORD-1:0] word_out,
  output logic                        word_valid,
  input  logic                        word_ready,
  output logic                        frame_err,
  output logic                        overrun,
  output logic [2:0]                  fsm_state
);

  localparam int W   = 8 * BYTES_PER_WORD;
  localparam int CW  = $clog2(CLKS_PER_BIT + 1);
  localparam int BIW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

`ifdef UART_WORD_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3,
                            PARITY = 3'd4} state_t;
  logic par_bad;
`else
  typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3} state_t;
`endif

  state_t          state;
  logic            sync1, line;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic [BIW-1:0]  byte_idx;
  logic [W-1:0]    word_acc;
  logic            word_done;
  logic            stop_wait;

  assign fsm_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      line  <= 1'b1;
    end else begin
      sync1 <= from_computer;
      line  <= sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      byte_idx  <= '0;
      word_acc  <= '0;
      word_done <= 1'b0;
      stop_wait <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_WORD_RX_PARITY_EN
      par_bad   <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      word_done <= 1'b0;
      case (state)
        IDLE: begin
          if (!line) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          // Mid-bit recheck rejects short glitches without flagging an error.
          if (cnt == CW'(CLKS_PER_BIT / 2)) begin
            cnt <= '0;
            if (line) begin
              state <= IDLE;
            end else begin
              bit_idx <= '0;
              state   <= DATA;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            cnt       <= '0;
            shift     <= {line, shift[7:1]};
            bit_idx   <= bit_idx + 1'b1;
            stop_wait <= 1'b0;
            if (bit_idx == 3'd7) begin
`ifdef UART_WORD_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_WORD_RX_PARITY_EN
        PARITY: begin
          if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            cnt   <= '0;
            state <= STOP;
            if (line != ^shift) begin
              frame_err <= 1'b1;
              par_bad   <= 1'b1;
              byte_idx  <= '0;
            end else begin
              par_bad <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (stop_wait) begin
            // Broken frame: hold here until the line returns to idle.
            if (line) begin
              stop_wait <= 1'b0;
              state     <= IDLE;
            end
          end else if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            cnt <= '0;
            if (line) begin
              state <= IDLE;
`ifdef UART_WORD_RX_PARITY_EN
              if (!par_bad)
`endif
              begin
                word_acc <= (word_acc << 8) | W'(shift);
                if (byte_idx == BIW'(BYTES_PER_WORD - 1)) begin
                  byte_idx  <= '0;
                  word_done <= 1'b1;
                end else begin
                  byte_idx <= byte_idx + 1'b1;
                end
              end
            end else begin
              frame_err <= 1'b1;
              byte_idx  <= '0;
              stop_wait <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake: a word transfers on any edge with word_valid && word_ready; word_valid
  // then stays high only if a new word completes on that same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_out   <= '0;
      word_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (word_done) begin
        if (!word_valid || word_ready) begin
          word_out   <= word_acc;
          word_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_word_rx.sv
// Bench for uart_word_rx: serial driver tasks, byte-level reference model feeding an
// expected-word queue, and a monitor that checks every accepted word and pulse counts.
module tb_uart_word_rx;
  localparam int CPB = 434;
  localparam int BPW = 2;
  localparam int W   = 8 * BPW;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         from_computer = 1'b1;
  logic         word_ready = 1'b1;
  logic [W-1:0] word_out;
  logic         word_valid, frame_err, overrun;
  logic [2:0]   fsm_state;

  int tests = 0;
  int fails = 0;
  int fe_cnt = 0, ovr_cnt = 0, exp_fe = 0, exp_ovr = 0;
  bit glitch_win = 1'b0, glitch_bad = 1'b0, prev_accept = 1'b0;

  logic [W-1:0] exp_q[$];
  logic [7:0]   bytes_q[$];

  uart_word_rx #(.CLKS_PER_BIT(CPB), .BYTES_PER_WORD(BPW)) dut (
    .clk(clk), .rst(rst), .from_computer(from_computer),
    .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
    .frame_err(frame_err), .overrun(overrun), .fsm_state(fsm_state)
  );

  // 50 MHz clock: 434 cycles per bit gives 8680 ns per bit.
  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: complete good bytes group into words, first byte most significant.
  task automatic model_byte(input logic [7:0] d, input bit stop_ok, input bit par_ok);
    logic [W-1:0] w;
    bit ok;
    ok = stop_ok;
`ifdef UART_WORD_RX_PARITY_EN
    ok = ok && par_ok;
    if (!par_ok) exp_fe++;
`endif
    if (!stop_ok) exp_fe++;
    if (!ok) begin
      bytes_q.delete();
    end else begin
      bytes_q.push_back(d);
      if (bytes_q.size() == BPW) begin
        w = '0;
        foreach (bytes_q[i]) w = (w << 8) | W'(bytes_q[i]);
        bytes_q.delete();
        if (exp_q.size() > 0 && !word_ready) exp_ovr++;
        else exp_q.push_back(w);
      end
    end
  endtask

  task automatic drive_bit(input logic b);
    @(negedge clk);
    from_computer = b;
    repeat (CPB - 1) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input bit stop_ok, input bit par_ok);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_WORD_RX_PARITY_EN
    drive_bit((^d) ^ !par_ok);
`endif
    model_byte(d, stop_ok, par_ok);
    drive_bit(stop_ok);
    @(negedge clk);
    from_computer = 1'b1;
    repeat (CPB / 2) @(negedge clk);
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk);
    #1 word_ready = r;
  endtask

  // Monitor: pops expected words on acceptance and counts error pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) fe_cnt++;
      if (overrun) ovr_cnt++;
      if (glitch_win && fsm_state > 3'd1) glitch_bad = 1'b1;
      if (prev_accept) check("valid_drop_after_accept", {31'd0, word_valid}, 32'd0);
      prev_accept = 1'b0;
      if (word_valid && word_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 32'(word_out), 32'hFFFF_FFFF);
        end else begin
          check("word_out", 32'(word_out), 32'(exp_q.pop_front()));
        end
        prev_accept = 1'b1;
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_word_out", 32'(word_out), 32'd0);
    check("reset_valid", {31'd0, word_valid}, 32'd0);
    check("reset_err_pulses", {30'd0, frame_err, overrun}, 32'd0);
    check("reset_state", 32'(fsm_state), 32'd0);
    rst = 1'b0;
    repeat (CPB) @(negedge clk);

    // Two bytes, consumer always ready.
    send_byte(8'h01, 1'b1, 1'b1);
    send_byte(8'h25, 1'b1, 1'b1);
    repeat (10) @(negedge clk);

    // Consumer stalled: the second word is dropped.
    set_ready(1'b0);
    send_byte(8'h01, 1'b1, 1'b1);
    send_byte(8'h25, 1'b1, 1'b1);
    send_byte(8'hAB, 1'b1, 1'b1);
    send_byte(8'hCD, 1'b1, 1'b1);
    @(negedge clk);
    check("stalled_valid", {31'd0, word_valid}, 32'd1);
    check("stalled_word_kept", 32'(word_out), 32'h0125);
    check("overrun_count", 32'(ovr_cnt), 32'(exp_ovr));
    set_ready(1'b1);
    repeat (4) @(negedge clk);
    check("valid_after_drain", {31'd0, word_valid}, 32'd0);

    // Bad stop bit restarts word assembly.
    send_byte(8'h01, 1'b0, 1'b1);
    send_byte(8'h12, 1'b1, 1'b1);
    send_byte(8'h34, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    check("frame_err_count", 32'(fe_cnt), 32'(exp_fe));

    // 2000 ns low glitch on an idle line.
    @(negedge clk);
    glitch_win = 1'b1;
    from_computer = 1'b0;
    repeat (100) @(negedge clk);
    from_computer = 1'b1;
    repeat (CPB) @(negedge clk);
    glitch_win = 1'b0;
    check("glitch_state_bound", {31'd0, glitch_bad}, 32'd0);
    check("glitch_back_idle", 32'(fsm_state), 32'd0);
    check("glitch_no_frame_err", 32'(fe_cnt), 32'(exp_fe));

    // Reset during the second byte abandons the partial word.
    send_byte(8'h11, 1'b1, 1'b1);
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    bytes_q.delete();
    repeat (CPB) @(negedge clk);
    set_ready(1'b0);
    send_byte(8'h56, 1'b1, 1'b1);
    send_byte(8'h78, 1'b1, 1'b1);
    @(negedge clk);
    check("post_reset_valid", {31'd0, word_valid}, 32'd1);
    check("post_reset_word", 32'(word_out), 32'h5678);
    check("post_reset_no_overrun", 32'(ovr_cnt), 32'(exp_ovr));
    set_ready(1'b1);
    repeat (4) @(negedge clk);

`ifdef UART_WORD_RX_PARITY_EN
    send_byte(8'h25, 1'b1, 1'b0);
    send_byte(8'h01, 1'b1, 1'b1);
    send_byte(8'h25, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    check("parity_frame_err", 32'(fe_cnt), 32'(exp_fe));
`endif

    // Random bytes, occasional bad stop bit.
    for (int i = 0; i < 2; i++) begin
      send_byte(8'($urandom_range(0, 255)), $urandom_range(0, 3) != 0, 1'b1);
    end

    for (int i = 0; i < 1000 && exp_q.size() > 0; i++) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("final_frame_err_count", 32'(fe_cnt), 32'(exp_fe));
    check("final_overrun_count", 32'(ovr_cnt), 32'(exp_ovr));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
